// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with modulus, prescaler and wrap/saturate boundary mode.
// Boundary steps raise a one-cycle wrap pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 0,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             overflow,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAXV  = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 1);
  localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] load_clamped;

  assign at_limit     = up_down ? (out == MAXV) : (out == '0);
  assign tick         = enable && (pre == PLAST);
  assign boundary     = tick && at_limit;
  assign load_clamped = (load_value > MAXV) ? MAXV : load_value;

  // Value the count takes if a step happens this cycle; saturate mode simply holds at the limit.
  always_comb begin
    step_value = out;
    if (up_down) begin
      if (out != MAXV)    step_value = out + WIDTH'(1);
      else if (!SATURATE) step_value = '0;
    end else begin
      if (out != '0)      step_value = out - WIDTH'(1);
      else if (!SATURATE) step_value = MAXV;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out      <= '0;
      pre      <= '0;
      wrap     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        out <= '0;
        pre <= '0;
      end else if (load) begin
        out <= load_clamped;
        pre <= '0;
      end else if (enable) begin
        if (tick) begin
          pre  <= '0;
          out  <= step_value;
          wrap <= at_limit;
        end else begin
          pre <= pre + PW'(1);
        end
      end
      // A boundary step wins over a simultaneous clear_ovf.
      if (boundary && !clear && !load) overflow <= 1'b1;
      else if (clear_ovf)              overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream,
// and each vector names the instance whose registered outputs it expects.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset, enable, up_down, clear, load, clear_ovf;
  logic [7:0] load_value;

  logic [7:0] out_def, out_mod, out_pre;
  logic [3:0] out_sat;
  logic       wrap_def, wrap_mod, wrap_sat, wrap_pre;
  logic       ovf_def, ovf_mod, ovf_sat, ovf_pre;
  logic       atl_def, atl_mod, atl_sat, atl_pre;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    string      name;
    logic       rst, en, ud, clr, ld;
    logic [7:0] lv;
    logic       cov;
    int         dut;
    logic [7:0] exp_out;
    logic       exp_wrap, exp_ovf, exp_atl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  updown_mod_counter u_def (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
    .out(out_def), .wrap(wrap_def), .overflow(ovf_def), .at_limit(atl_def));

  updown_mod_counter #(.MODULO(10)) u_mod (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
    .out(out_mod), .wrap(wrap_mod), .overflow(ovf_mod), .at_limit(atl_mod));

  updown_mod_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value[3:0]), .clear_ovf(clear_ovf),
    .out(out_sat), .wrap(wrap_sat), .overflow(ovf_sat), .at_limit(atl_sat));

  updown_mod_counter #(.PRESCALE(3)) u_pre (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .clear_ovf(clear_ovf),
    .out(out_pre), .wrap(wrap_pre), .overflow(ovf_pre), .at_limit(atl_pre));

  function automatic vec_t mk(string name, logic rst, logic en, logic ud, logic clr, logic ld,
                              logic [7:0] lv, logic cov, int dut, logic [7:0] eo,
                              logic ew, logic eov, logic ea);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.ud = ud; v.clr = clr; v.ld = ld;
    v.lv = lv; v.cov = cov; v.dut = dut;
    v.exp_out = eo; v.exp_wrap = ew; v.exp_ovf = eov; v.exp_atl = ea;
    return v;
  endfunction

  function automatic logic [10:0] actual_of(int dut);
    case (dut)
      0:       return {out_def, wrap_def, ovf_def, atl_def};
      1:       return {out_mod, wrap_mod, ovf_mod, atl_mod};
      2:       return {4'h0, out_sat, wrap_sat, ovf_sat, atl_sat};
      default: return {out_pre, wrap_pre, ovf_pre, atl_pre};
    endcase
  endfunction

  task automatic checkOutput();
    vec_t        e;
    logic [10:0] act, req;
    check_count++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one queued");
      return;
    end
    e   = sb.pop_front();
    act = actual_of(e.dut);
    req = {e.exp_out, e.exp_wrap, e.exp_ovf, e.exp_atl};
    if (act === req) pass_count++;
    else
      $display("[TB] FAIL %s (dut%0d): got out=%0h wrap=%b ovf=%b at_limit=%b, required out=%0h wrap=%b ovf=%b at_limit=%b",
               e.name, e.dut, act[10:3], act[2], act[1], act[0],
               e.exp_out, e.exp_wrap, e.exp_ovf, e.exp_atl);
  endtask

  // Drive on the falling edge, queue the expectation, and compare just after the rising edge.
  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    reset = v.rst; enable = v.en; up_down = v.ud; clear = v.clr;
    load = v.ld; load_value = v.lv; clear_ovf = v.cov;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pre_exp[9];
    logic [7:0] gap_exp[5];
    logic       gap_en[5];
    pre_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
    gap_exp = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
    gap_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0;
    load = 1'b0; load_value = 8'h00; clear_ovf = 1'b0;

    // name, rst, en, ud, clr, ld, lv, cov, dut, out, wrap, ovf, at_limit
    vecs.push_back(mk("reset_1",      0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk("reset_load",   0, 1, 1, 0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk("count_up",   1, 1, 1, 0, 0, 8'h00, 0, 0, 8'(i), 0, 0, 0));
    vecs.push_back(mk("load_fe_en",   1, 1, 1, 0, 1, 8'hFE, 0, 0, 8'hFE, 0, 0, 0));
    vecs.push_back(mk("up_to_ff",     1, 1, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 1));
    vecs.push_back(mk("wrap_to_00",   1, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk("after_wrap",   1, 1, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 1, 0));
    vecs.push_back(mk("ovf_sticky",   1, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 1, 0));
    vecs.push_back(mk("clear_ovf",    1, 0, 1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0));
    vecs.push_back(mk("mod_reset",    0, 0, 0, 0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 1));
    vecs.push_back(mk("mod_clamp",    1, 0, 1, 0, 1, 8'd15, 0, 1, 8'd9,  0, 0, 1));
    vecs.push_back(mk("mod_load_1",   1, 0, 0, 0, 1, 8'd1,  0, 1, 8'd1,  0, 0, 0));
    vecs.push_back(mk("mod_down_0",   1, 1, 0, 0, 0, 8'h00, 0, 1, 8'd0,  0, 0, 1));
    vecs.push_back(mk("mod_wrap_9",   1, 1, 0, 0, 0, 8'h00, 0, 1, 8'd9,  1, 1, 0));
    vecs.push_back(mk("mod_down_8",   1, 1, 0, 0, 0, 8'h00, 0, 1, 8'd8,  0, 1, 0));
    vecs.push_back(mk("clear_vs_load",1, 1, 0, 1, 1, 8'd5,  0, 1, 8'd0,  0, 1, 1));
    vecs.push_back(mk("sat_reset",    0, 0, 1, 0, 0, 8'h00, 0, 2, 8'd0,  0, 0, 0));
    vecs.push_back(mk("sat_load_14",  1, 0, 1, 0, 1, 8'd14, 0, 2, 8'd14, 0, 0, 0));
    vecs.push_back(mk("sat_up_15",    1, 1, 1, 0, 0, 8'h00, 0, 2, 8'd15, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("sat_blocked",1, 1, 1, 0, 0, 8'h00, 0, 2, 8'd15, 1, 1, 1));
    vecs.push_back(mk("sat_down_14",  1, 1, 0, 0, 0, 8'h00, 0, 2, 8'd14, 0, 1, 0));
    vecs.push_back(mk("sat_load_0",   1, 0, 0, 0, 1, 8'd0,  1, 2, 8'd0,  0, 0, 1));
    vecs.push_back(mk("ovf_set_wins", 1, 1, 0, 0, 0, 8'h00, 1, 2, 8'd0,  1, 1, 1));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Prescaler: a step on every third enabled cycle.
    applyStimulus(mk("pre_reset", 0, 0, 1, 0, 0, 8'h00, 0, 3, 8'd0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      applyStimulus(mk("pre_run", 1, 1, 1, 0, 0, 8'h00, 0, 3, pre_exp[i], 0, 0, 0));

    // Two disabled cycles push the next step out by two cycles.
    for (int i = 0; i < 5; i++)
      applyStimulus(mk("pre_gap", 1, gap_en[i], 1, 0, 0, 8'h00, 0, 3, gap_exp[i], 0, 0, 0));

    // Reset in the middle of a prescale period restarts the prescaler from zero.
    applyStimulus(mk("pre_mid_1",   1, 1, 1, 0, 0, 8'h00, 0, 3, 8'd4, 0, 0, 0));
    applyStimulus(mk("pre_mid_2",   1, 1, 1, 0, 0, 8'h00, 0, 3, 8'd4, 0, 0, 0));
    applyStimulus(mk("pre_rst_mid", 0, 1, 1, 0, 0, 8'h00, 0, 3, 8'd0, 0, 0, 0));
    applyStimulus(mk("pre_rel_1",   1, 1, 1, 0, 0, 8'h00, 0, 3, 8'd0, 0, 0, 0));
    applyStimulus(mk("pre_rel_2",   1, 1, 1, 0, 0, 8'h00, 0, 3, 8'd0, 0, 0, 0));
    applyStimulus(mk("pre_rel_3",   1, 1, 1, 0, 0, 8'h00, 0, 3, 8'd1, 0, 0, 0));

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
